mbinit_partner_responder: RTL and testbench

Parametrised module-partner responder for MBINIT sideband request/response substates (REPAIRVAL, and any substate using the init/result/done exchange). The block waits for the link partner's init, result and done requests, arbitrates sideband-busy and sends the matching responses. It carries a configurable-width result payload and runs a timeout on every wait state. It sits between the MBINIT substate controller, the sideband TX/RX message layer, and the per-lane comparison logic.

---
 rtl/mbinit_partner_responder_if.sv | 54 +++++
 rtl/mbinit_partner_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mbinit_partner_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mbinit_partner_responder_if.sv
// Bundle of the responder's sideband, substate-control and lane-result signals.
// The master side is the environment (substate controller, sideband TX/RX layer,
// lane checker); the slave side is the responder itself.
interface mbinit_partner_responder_if #(
   parameter int MSG_W = 4,
   parameter int RES_W = 1
);
   // Substate control and sideband RX
   logic             i_enable;
   logic [MSG_W-1:0] i_rx_msg;
   logic             i_msg_valid;
   // Lane comparison result
   logic [RES_W-1:0] i_result;
   // Sideband TX status
   logic             i_busy_sideband;
   logic             i_falling_edge_busy;
   // Responses and status back to the environment
   logic [MSG_W-1:0] o_tx_msg;
   logic             o_tx_valid;
   logic [RES_W-1:0] o_result;
   logic             o_done;
   logic             o_timeout;
   logic             o_enable_cons;

   modport master (
      output i_enable,
      output i_rx_msg,
      output i_msg_valid,
      output i_result,
      output i_busy_sideband,
      output i_falling_edge_busy,
      input  o_tx_msg,
      input  o_tx_valid,
      input  o_result,
      input  o_done,
      input  o_timeout,
      input  o_enable_cons
   );

   modport slave (
      input  i_enable,
      input  i_rx_msg,
      input  i_msg_valid,
      input  i_result,
      input  i_busy_sideband,
      input  i_falling_edge_busy,
      output o_tx_msg,
      output o_tx_valid,
      output o_result,
      output o_done,
      output o_timeout,
      output o_enable_cons
   );
endinterface

// File: rtl/mbinit_partner_responder.sv
// MBINIT module-partner responder.
// Waits for the partner's init / result / done requests, waits for the sideband
// TX to be free, then sends the matching response (request code + 1). The result
// response carries a latched copy of the lane checker's result. Every wait for a
// partner request is guarded by a timeout. All outputs are registered and decoded
// from the next state so they line up with the state they describe.
// TIMEOUT_CYC must be at least 1 and below 2**TIMEOUT_W.
module mbinit_partner_responder #(
   parameter int               MSG_W       = 4,
   parameter int               RES_W       = 1,
   parameter logic [MSG_W-1:0] INIT_REQ    = MSG_W'(4'h1),
   parameter logic [MSG_W-1:0] RESULT_REQ  = MSG_W'(4'h3),
   parameter logic [MSG_W-1:0] DONE_REQ    = MSG_W'(4'h5),
   parameter int               TIMEOUT_W   = 20,
   parameter int               TIMEOUT_CYC = 800000
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   mbinit_partner_responder_if.slave bus
);

   // Response codes are the request code plus one.
   localparam logic [MSG_W-1:0] INIT_RSP   = MSG_W'(INIT_REQ + 1'b1);
   localparam logic [MSG_W-1:0] RESULT_RSP = MSG_W'(RESULT_REQ + 1'b1);
   localparam logic [MSG_W-1:0] DONE_RSP   = MSG_W'(DONE_REQ + 1'b1);

   // Counter value seen on the last permitted wait cycle.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_INIT = 3'd1,
      BUSY_CHK  = 3'd2,
      SEND      = 3'd3,
      WAIT_REQ  = 3'd4,
      DONE      = 3'd5,
      ERROR     = 3'd6
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [MSG_W-1:0]     pend_reg;
   logic [MSG_W-1:0]     pend_next;
   logic [TIMEOUT_W-1:0] cnt_reg;
   logic [TIMEOUT_W-1:0] cnt_next;

   logic [MSG_W-1:0]     tx_msg_reg;
   logic [MSG_W-1:0]     tx_msg_next;
   logic                 tx_valid_reg;
   logic                 tx_valid_next;
   logic [RES_W-1:0]     result_reg;
   logic [RES_W-1:0]     result_next;
   logic                 done_reg;
   logic                 done_next;
   logic                 timeout_reg;
   logic                 timeout_next;
   logic                 enable_cons_reg;
   logic                 enable_cons_next;

   // Request decode; only meaningful in the two wait states.
   logic                 req_init;
   logic                 req_result;
   logic                 req_done;
   logic                 req_any;
   logic                 timeout_hit;
   logic                 next_is_wait;

   assign req_init    = bus.i_msg_valid && (bus.i_rx_msg == INIT_REQ);
   assign req_result  = bus.i_msg_valid && (bus.i_rx_msg == RESULT_REQ);
   assign req_done    = bus.i_msg_valid && (bus.i_rx_msg == DONE_REQ);
   assign req_any     = req_init || req_result || req_done;
   assign timeout_hit = (cnt_reg == TO_LAST);

   // Next-state, pending-response, result-latch and output decode.
   always_comb begin
      state_next  = state_reg;
      pend_next   = pend_reg;
      result_next = result_reg;

      if (!bus.i_enable) begin
         // Enable low wins over everything and abandons any response in flight.
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE: begin
               state_next = WAIT_INIT;
            end
            WAIT_INIT: begin
               // A request on the expiry cycle is accepted rather than timing out.
               if (req_init) begin
                  state_next = BUSY_CHK;
                  pend_next  = INIT_RSP;
               end else if (timeout_hit) begin
                  state_next = ERROR;
               end
            end
            BUSY_CHK: begin
               // Result payload is sampled on the cycle the response is launched.
               if (!bus.i_busy_sideband) begin
                  state_next = SEND;
                  if (pend_reg == RESULT_RSP) begin
                     result_next = bus.i_result;
                  end else begin
                     result_next = '0;
                  end
               end
            end
            SEND: begin
               if (bus.i_falling_edge_busy) begin
                  if (pend_reg == DONE_RSP) begin
                     state_next = DONE;
                  end else begin
                     state_next = WAIT_REQ;
                  end
               end
            end
            WAIT_REQ: begin
               // An init request here is a partner retry; answer it again.
               // Other valid codes are not ours and are dropped.
               if (req_any) begin
                  state_next = BUSY_CHK;
                  pend_next  = MSG_W'(bus.i_rx_msg + 1'b1);
               end else if (timeout_hit) begin
                  state_next = ERROR;
               end
            end
            DONE: begin
               state_next = DONE;
            end
            ERROR: begin
               state_next = ERROR;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      // Leaving the substate discards the latched payload.
      if (state_next == IDLE) begin
         result_next = '0;
      end

      // Timeout counter: zero on entry to a wait state, counts while staying.
      // The saturation guard keeps it from wrapping.
      next_is_wait = (state_next == WAIT_INIT) || (state_next == WAIT_REQ);
      cnt_next     = '0;
      if (next_is_wait && (state_next == state_reg)) begin
         if (cnt_reg == TO_LAST) begin
            cnt_next = cnt_reg;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end

      // Outputs decoded from the next state so they are registered in step with it.
      tx_valid_next    = (state_next == SEND);
      tx_msg_next      = (state_next == SEND) ? pend_next : '0;
      done_next        = (state_next == DONE);
      timeout_next     = (state_next == ERROR);
      enable_cons_next = (state_next != IDLE);
   end

   // State, pending response and timeout counter registers.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pend_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Registered outputs; reset clears them without waiting for a clock.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         tx_msg_reg      <= '0;
         tx_valid_reg    <= 1'b0;
         result_reg      <= '0;
         done_reg        <= 1'b0;
         timeout_reg     <= 1'b0;
         enable_cons_reg <= 1'b0;
      end else begin
         tx_msg_reg      <= tx_msg_next;
         tx_valid_reg    <= tx_valid_next;
         result_reg      <= result_next;
         done_reg        <= done_next;
         timeout_reg     <= timeout_next;
         enable_cons_reg <= enable_cons_next;
      end
   end

   assign bus.o_tx_msg      = tx_msg_reg;
   assign bus.o_tx_valid    = tx_valid_reg;
   assign bus.o_result      = result_reg;
   assign bus.o_done        = done_reg;
   assign bus.o_timeout     = timeout_reg;
   assign bus.o_enable_cons = enable_cons_reg;

endmodule

// File: tb/tb_mbinit_partner_responder.sv
// Self-checking bench for mbinit_partner_responder (RES_W=16, TIMEOUT_CYC=16).
// Each vector drives one clock cycle of inputs and states the outputs expected
// after that edge; expectations go through a scoreboard queue.
module tb_mbinit_partner_responder;
   localparam int MSG_W  = 4;
   localparam int RES_W  = 16;
   localparam int TO_CYC = 16;

   typedef struct {
      string       name;
      logic        en;
      logic        mv;
      logic [3:0]  msg;
      logic [15:0] res;
      logic        busy;
      logic        fe;
      logic [3:0]  x_msg;
      logic        x_v;
      logic [15:0] x_res;
      logic        x_done;
      logic        x_to;
      logic        x_cons;
   } vec_t;

   logic clk;
   logic rst_n;

   mbinit_partner_responder_if #(.MSG_W(MSG_W), .RES_W(RES_W)) bus ();

   mbinit_partner_responder #(
      .MSG_W      (MSG_W),
      .RES_W      (RES_W),
      .INIT_REQ   (4'h1),
      .RESULT_REQ (4'h3),
      .DONE_REQ   (4'h5),
      .TIMEOUT_W  (8),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .CLK  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input string n, input int en, input int mv, input int msg,
                      input int res, input int busy, input int fe,
                      input int xm, input int xv, input int xr,
                      input int xd, input int xt, input int xc);
      vec_t v;
      v.name   = n;
      v.en     = 1'(en);
      v.mv     = 1'(mv);
      v.msg    = 4'(msg);
      v.res    = 16'(res);
      v.busy   = 1'(busy);
      v.fe     = 1'(fe);
      v.x_msg  = 4'(xm);
      v.x_v    = 1'(xv);
      v.x_res  = 16'(xr);
      v.x_done = 1'(xd);
      v.x_to   = 1'(xt);
      v.x_cons = 1'(xc);
      tbl.push_back(v);
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs now.
   task automatic check_out();
      vec_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard: output sampled with no expectation queued");
      end else begin
         e = exp_q.pop_front();
         if ({bus.o_tx_msg, bus.o_tx_valid, bus.o_result, bus.o_done, bus.o_timeout, bus.o_enable_cons}
             !== {e.x_msg, e.x_v, e.x_res, e.x_done, e.x_to, e.x_cons}) begin
            n_err++;
            $display("FAIL %s: got msg=%h v=%b res=%h done=%b to=%b cons=%b, expected msg=%h v=%b res=%h done=%b to=%b cons=%b",
                     e.name, bus.o_tx_msg, bus.o_tx_valid, bus.o_result, bus.o_done, bus.o_timeout,
                     bus.o_enable_cons, e.x_msg, e.x_v, e.x_res, e.x_done, e.x_to, e.x_cons);
         end else begin
            $display("vec %0d %s: msg=%h v=%b res=%h done=%b to=%b cons=%b", n_vec, e.name,
                     bus.o_tx_msg, bus.o_tx_valid, bus.o_result, bus.o_done, bus.o_timeout, bus.o_enable_cons);
         end
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, check after the edge.
   task automatic run_vec(input vec_t v);
      bus.i_enable            = v.en;
      bus.i_msg_valid         = v.mv;
      bus.i_rx_msg            = v.msg;
      bus.i_result            = v.res;
      bus.i_busy_sideband     = v.busy;
      bus.i_falling_edge_busy = v.fe;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t hv;
      // Nominal init / result / done exchange with the sideband idle.
      add("en",          1,0,0,0,0,0,       0,0,0,0,0,1);
      add("init_req",    1,1,1,0,0,0,       0,0,0,0,0,1);
      add("init_rsp",    1,0,0,0,0,0,       2,1,0,0,0,1);
      add("init_hold",   1,0,0,0,0,0,       2,1,0,0,0,1);
      add("init_fe",     1,0,0,0,0,1,       0,0,0,0,0,1);
      add("res_req",     1,1,3,16'hA5F0,0,0, 0,0,0,0,0,1);
      add("res_rsp",     1,0,0,16'hA5F0,0,0, 4,1,16'hA5F0,0,0,1);
      add("res_fe",      1,0,0,0,0,1,       0,0,16'hA5F0,0,0,1);
      add("done_req",    1,1,5,0,0,0,       0,0,16'hA5F0,0,0,1);
      add("done_rsp",    1,0,0,0,0,0,       6,1,0,0,0,1);
      add("done_fe",     1,0,0,0,0,1,       0,0,0,1,0,1);
      add("done_hold",   1,1,1,0,0,0,       0,0,0,1,0,1);
      add("done_off",    0,0,0,0,0,0,       0,0,0,0,0,0);
      // Busy stall: five busy cycles in BUSY_CHK, response one cycle after release.
      add("b_en",        1,0,0,0,0,0,       0,0,0,0,0,1);
      add("b_init",      1,1,1,0,1,0,       0,0,0,0,0,1);
      for (int i = 0; i < 5; i++) add("b_stall", 1,0,0,0,1,0, 0,0,0,0,0,1);
      add("b_rsp",       1,0,0,0,0,0,       2,1,0,0,0,1);
      add("b_fe",        1,0,0,0,0,1,       0,0,0,0,0,1);
      // Ignored code, retry of init, init ignored while sending.
      add("ign_7",       1,1,7,0,0,0,       0,0,0,0,0,1);
      add("ign_7_after", 1,0,0,0,0,0,       0,0,0,0,0,1);
      add("retry_req",   1,1,1,0,0,0,       0,0,0,0,0,1);
      add("retry_rsp",   1,0,0,0,0,0,       2,1,0,0,0,1);
      add("send_ign",    1,1,1,0,0,0,       2,1,0,0,0,1);
      add("retry_fe",    1,0,0,0,0,1,       0,0,0,0,0,1);
      // Enable dropped while the result response is being sent.
      add("a_req",       1,1,3,16'h1234,0,0, 0,0,0,0,0,1);
      add("a_rsp",       1,0,0,16'h1234,0,0, 4,1,16'h1234,0,0,1);
      add("a_drop",      0,0,0,16'h1234,0,1, 0,0,0,0,0,0);
      // Timeout in WAIT_INIT after 16 cycles.
      add("t_en",        1,0,0,0,0,0,       0,0,0,0,0,1);
      for (int i = 0; i < TO_CYC - 1; i++) add("t_wait", 1,0,0,0,0,0, 0,0,0,0,0,1);
      add("t_expire",    1,0,0,0,0,0,       0,0,0,0,1,1);
      add("t_hold",      1,1,1,0,0,0,       0,0,0,0,1,1);
      add("t_off",       0,0,0,0,0,0,       0,0,0,0,0,0);
      // Request on the expiry cycle of WAIT_REQ wins; counter restarts afterwards.
      add("c_en",        1,0,0,0,0,0,       0,0,0,0,0,1);
      add("c_init",      1,1,1,0,0,0,       0,0,0,0,0,1);
      add("c_rsp",       1,0,0,0,0,0,       2,1,0,0,0,1);
      add("c_fe",        1,0,0,0,0,1,       0,0,0,0,0,1);
      for (int i = 0; i < TO_CYC - 1; i++) add("c_wait", 1,0,0,0,0,0, 0,0,0,0,0,1);
      add("c_collide",   1,1,3,16'hBEEF,0,0, 0,0,0,0,0,1);
      add("c_res_rsp",   1,0,0,16'hBEEF,0,0, 4,1,16'hBEEF,0,0,1);
      add("c_res_fe",    1,0,0,0,0,1,       0,0,16'hBEEF,0,0,1);
      for (int i = 0; i < TO_CYC - 1; i++) add("c_wait2", 1,0,0,0,0,0, 0,0,16'hBEEF,0,0,1);
      add("c_expire2",   1,0,0,0,0,0,       0,0,16'hBEEF,0,1,1);
      add("c_off",       0,0,0,0,0,0,       0,0,0,0,0,0);

      // Reset state.
      rst_n                   = 1'b0;
      bus.i_enable            = 1'b0;
      bus.i_msg_valid         = 1'b0;
      bus.i_rx_msg            = '0;
      bus.i_result            = '0;
      bus.i_busy_sideband     = 1'b0;
      bus.i_falling_edge_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      hv = '{name:"reset", en:0, mv:0, msg:0, res:0, busy:0, fe:0,
             x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:0};
      exp_q.push_back(hv);
      check_out();
      rst_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Asynchronous reset in the middle of a result response.
      run_vec('{name:"r_en", en:1, mv:0, msg:0, res:0, busy:0, fe:0,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:1});
      run_vec('{name:"r_init", en:1, mv:1, msg:1, res:0, busy:0, fe:0,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:1});
      run_vec('{name:"r_irsp", en:1, mv:0, msg:0, res:0, busy:0, fe:0,
                x_msg:2, x_v:1, x_res:0, x_done:0, x_to:0, x_cons:1});
      run_vec('{name:"r_ife", en:1, mv:0, msg:0, res:0, busy:0, fe:1,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:1});
      run_vec('{name:"r_rreq", en:1, mv:1, msg:3, res:16'h5A5A, busy:0, fe:0,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:1});
      run_vec('{name:"r_rrsp", en:1, mv:0, msg:0, res:16'h5A5A, busy:0, fe:0,
                x_msg:4, x_v:1, x_res:16'h5A5A, x_done:0, x_to:0, x_cons:1});
      #2;
      rst_n = 1'b0;
      hv = '{name:"rst_mid_send", en:1, mv:0, msg:0, res:16'h5A5A, busy:0, fe:0,
             x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:0};
      exp_q.push_back(hv);
      #1;
      check_out();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_vec('{name:"post_rst_off", en:0, mv:0, msg:0, res:0, busy:0, fe:0,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:0});
      run_vec('{name:"post_rst_en", en:1, mv:0, msg:0, res:0, busy:0, fe:0,
                x_msg:0, x_v:0, x_res:0, x_done:0, x_to:0, x_cons:1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
